// File: rtl/fifo_idx_ctrl_pkg.sv
// Shared helpers for the FIFO index controller: pointer increment with explicit
// wrap at DEPTH, and the width helper used to size pointers and the occupancy count.
package fifo_idx_ctrl_pkg;

    // Smallest width w (at least 1) such that 2^w >= n.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // DEPTH need not be a power of two, so the wrap is explicit.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_idx_ctrl_if.sv
// Push/pop request and index-map strobe/status bundle of the FIFO index controller.
interface fifo_idx_ctrl_if #(
    parameter int unsigned PTR_SZ = 2,
    parameter int unsigned CNT_SZ = 2
);
    logic              push_req;
    logic              pop_req;
    logic              write_en;
    logic [PTR_SZ-1:0] waddr;
    logic              read_en;
    logic [PTR_SZ-1:0] raddr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CNT_SZ-1:0] count;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output push_req, pop_req,
        input  write_en, waddr, read_en, raddr,
        input  full, empty, almost_full, count, err_ovf, err_udf
    );

    modport slave (
        input  push_req, pop_req,
        output write_en, waddr, read_en, raddr,
        output full, empty, almost_full, count, err_ovf, err_udf
    );
endinterface

// File: rtl/fifo_ptr_wrap.sv
// One FIFO pointer register that advances on adv_i and wraps from DEPTH-1 to 0.
module fifo_ptr_wrap
    import fifo_idx_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned PTR_SZ = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [PTR_SZ-1:0] ptr_o
);
    logic [PTR_SZ-1:0] ptr_q;
    logic [PTR_SZ-1:0] ptr_d;

    // Next pointer: hold, or step with wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = PTR_SZ'(ptr_next(32'(ptr_q), DEPTH));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_idx_ctrl.sv
// Pointer/occupancy controller for a router input FIFO index map.
// Optional sticky overflow/underflow flags under macro FIFO_IDX_CTRL_ERR_EN.
module fifo_idx_ctrl
    import fifo_idx_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned PTR_SZ   = idx_width(DEPTH),
    parameter int unsigned CNT_SZ   = idx_width(DEPTH + 32'd1),
    parameter int unsigned AF_LEVEL = 2
) (
    input logic           clk,
    input logic           rst_n,
    fifo_idx_ctrl_if.slave bus
);
    logic [CNT_SZ-1:0] count_q;
    logic [CNT_SZ-1:0] count_d;
    logic [PTR_SZ-1:0] wr_ptr_s;
    logic [PTR_SZ-1:0] rd_ptr_s;
    logic              full_s;
    logic              empty_s;
    logic              push_acc_s;
    logic              pop_acc_s;

    assign full_s     = (count_q == CNT_SZ'(DEPTH));
    assign empty_s    = (count_q == CNT_SZ'(0));
    // Acceptance looks only at the registered count, never at the other request.
    assign push_acc_s = bus.push_req & ~full_s;
    assign pop_acc_s  = bus.pop_req & ~empty_s;

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (push_acc_s),
        .ptr_o (wr_ptr_s)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (pop_acc_s),
        .ptr_o (rd_ptr_s)
    );

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_d = count_q + CNT_SZ'(1);
            2'b01:   count_d = count_q - CNT_SZ'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef FIFO_IDX_CTRL_ERR_EN
    logic err_ovf_q;
    logic err_udf_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | (bus.push_req & full_s);
            err_udf_q <= err_udf_q | (bus.pop_req & empty_s);
        end
    end

    assign bus.err_ovf = err_ovf_q;
    assign bus.err_udf = err_udf_q;
`else
    assign bus.err_ovf = 1'b0;
    assign bus.err_udf = 1'b0;
`endif

    assign bus.write_en    = push_acc_s;
    assign bus.waddr       = wr_ptr_s;
    assign bus.read_en     = pop_acc_s;
    assign bus.raddr       = rd_ptr_s;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.almost_full = (count_q >= CNT_SZ'(AF_LEVEL));
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fifo_idx_ctrl.sv
// Directed bench for fifo_idx_ctrl at DEPTH=3, AF_LEVEL=2.
module tb_fifo_idx_ctrl;
`ifdef FIFO_IDX_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fifo_idx_ctrl_if #(.PTR_SZ(2), .CNT_SZ(2)) bus ();

    fifo_idx_ctrl #(.DEPTH(3), .PTR_SZ(2), .CNT_SZ(2), .AF_LEVEL(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic pop);
        bus.push_req = push;
        bus.pop_req  = pop;
        #1;
    endtask

    initial begin
        int exp_w;
        int exp_r;
        vectors     = 0;
        miscompares = 0;
        rst_n        = 1'b0;
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_empty", bus.empty, 32'd1);
        chk("rst_full", bus.full, 32'd0);
        chk("rst_af", bus.almost_full, 32'd0);
        chk("rst_count", bus.count, 32'd0);
        chk("rst_wen", bus.write_en, 32'd0);
        chk("rst_ren", bus.read_en, 32'd0);
        chk("rst_waddr", bus.waddr, 32'd0);
        chk("rst_raddr", bus.raddr, 32'd0);
        chk("rst_ovf", bus.err_ovf, 32'd0);
        chk("rst_udf", bus.err_udf, 32'd0);

        // Fill: waddr 0,1,2; count 1,2,3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            chk("fill_wen", bus.write_en, 32'd1);
            chk("fill_waddr", bus.waddr, 32'(i));
            tick();
            chk("fill_count", bus.count, 32'(i + 1));
            chk("fill_af", bus.almost_full, (i >= 1) ? 32'd1 : 32'd0);
            chk("fill_full", bus.full, (i == 2) ? 32'd1 : 32'd0);
        end

        // Push while full is dropped
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0);
            chk("ovf_wen", bus.write_en, 32'd0);
            chk("ovf_waddr", bus.waddr, 32'd0);
            tick();
            chk("ovf_count", bus.count, 32'd3);
            chk("ovf_flag", bus.err_ovf, 32'(ERR_EXP));
        end

        // Drain: raddr 0,1,2; count 2,1,0
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            chk("drain_ren", bus.read_en, 32'd1);
            chk("drain_raddr", bus.raddr, 32'(i));
            tick();
            chk("drain_count", bus.count, 32'(2 - i));
        end
        chk("drain_empty", bus.empty, 32'd1);
        chk("drain_full", bus.full, 32'd0);

        // Pop while empty is dropped
        drive(1'b0, 1'b1);
        chk("udf_ren", bus.read_en, 32'd0);
        tick();
        chk("udf_count", bus.count, 32'd0);
        chk("udf_flag", bus.err_udf, 32'(ERR_EXP));
        chk("udf_ovf_sticky", bus.err_ovf, 32'(ERR_EXP));

        // Wrap stress: push, then alternate push/pop, then final pop
        exp_w = 0;
        exp_r = 0;
        drive(1'b1, 1'b0);
        chk("wrap_waddr", bus.waddr, 32'(exp_w));
        exp_w = (exp_w == 2) ? 0 : exp_w + 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0);
            chk("wrap_wen", bus.write_en, 32'd1);
            chk("wrap_waddr", bus.waddr, 32'(exp_w));
            exp_w = (exp_w == 2) ? 0 : exp_w + 1;
            tick();
            chk("wrap_count2", bus.count, 32'd2);
            drive(1'b0, 1'b1);
            chk("wrap_ren", bus.read_en, 32'd1);
            chk("wrap_raddr", bus.raddr, 32'(exp_r));
            exp_r = (exp_r == 2) ? 0 : exp_r + 1;
            tick();
            chk("wrap_count1", bus.count, 32'd1);
        end
        drive(1'b0, 1'b1);
        chk("wrap_raddr", bus.raddr, 32'(exp_r));
        tick();
        chk("wrap_empty", bus.empty, 32'd1);
        chk("wrap_wptr", bus.waddr, 32'd2);
        chk("wrap_rptr", bus.raddr, 32'd2);

        // Simultaneous push+pop at count=0: push only
        drive(1'b1, 1'b1);
        chk("sim0_wen", bus.write_en, 32'd1);
        chk("sim0_ren", bus.read_en, 32'd0);
        tick();
        chk("sim0_count", bus.count, 32'd1);

        // At count=1: both accepted
        drive(1'b1, 1'b1);
        chk("sim1_wen", bus.write_en, 32'd1);
        chk("sim1_ren", bus.read_en, 32'd1);
        chk("sim1_waddr", bus.waddr, 32'd0);
        chk("sim1_raddr", bus.raddr, 32'd2);
        tick();
        chk("sim1_count", bus.count, 32'd1);

        drive(1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0);
        tick();
        chk("sim3_pre_full", bus.full, 32'd1);

        // At count=3: pop only
        drive(1'b1, 1'b1);
        chk("sim3_wen", bus.write_en, 32'd0);
        chk("sim3_ren", bus.read_en, 32'd1);
        chk("sim3_raddr", bus.raddr, 32'd0);
        tick();
        chk("sim3_count", bus.count, 32'd2);

        // Asynchronous reset mid-cycle at count=2
        drive(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", bus.count, 32'd0);
        chk("arst_empty", bus.empty, 32'd1);
        chk("arst_waddr", bus.waddr, 32'd0);
        chk("arst_raddr", bus.raddr, 32'd0);
        chk("arst_ovf", bus.err_ovf, 32'd0);
        chk("arst_udf", bus.err_udf, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_count", bus.count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
